// File: rtl/fetch_pc_sequencer.sv
// Program-counter owner and single-outstanding instruction fetcher.
// Taken branches redirect the PC and squash any wrong-path fetch; misaligned targets trap.
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    output logic        oIMEM_VALID,
    output logic [31:0] oIMEM_ADDR,
    input  logic        iIMEM_READY,
    input  logic        iIMEM_RVALID,
    input  logic [31:0] iIMEM_RDATA,
    output logic        oIR_VALID,
    output logic [31:0] oIR,
    output logic [31:0] oIR_PC,
    input  logic        iIR_READY,
    input  logic        iBR_VALID,
    input  logic        iBR_TAKEN,
    input  logic [31:0] iBR_PC,
    input  logic [31:0] iBR_OFFSET,
    output logic        oTRAP
);

    // state  | meaning
    // S_REQ  | fetch request presented at pc
    // S_WAIT | request accepted, waiting for read data
    // S_OUT  | instruction held for decode
    // S_HALT | misaligned branch target, frozen until reset
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_HALT} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic        drop, drop_nxt;
    logic [31:0] ir_q, ir_nxt;
    logic [31:0] ir_pc_q, ir_pc_nxt;
    logic        trap_q, trap_nxt;

    logic        redirect;
    logic [31:0] target;
    logic        misaligned;
    logic        imem_hs;
    logic        ir_hs;

    assign redirect    = iBR_VALID & iBR_TAKEN;
    assign target      = iBR_PC + iBR_OFFSET;
    assign misaligned  = |target[1:0];

    assign oIMEM_VALID = (state == S_REQ) & ~iRST;
    assign oIMEM_ADDR  = pc;
    assign oIR_VALID   = (state == S_OUT);
    assign oIR         = ir_q;
    assign oIR_PC      = ir_pc_q;
    assign oTRAP       = trap_q;

    assign imem_hs     = oIMEM_VALID & iIMEM_READY;
    assign ir_hs       = oIR_VALID & iIR_READY;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            drop    <= 1'b0;
            ir_q    <= 32'h0;
            ir_pc_q <= 32'h0;
            trap_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            drop    <= drop_nxt;
            ir_q    <= ir_nxt;
            ir_pc_q <= ir_pc_nxt;
            trap_q  <= trap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        drop_nxt  = drop;
        ir_nxt    = ir_q;
        ir_pc_nxt = ir_pc_q;
        trap_nxt  = trap_q;

        // A redirect outranks every other event in the same cycle.
        if (state != S_HALT && redirect && misaligned) begin
            trap_nxt  = 1'b1;
            state_nxt = S_HALT;
        end else begin
            case (state)
                S_REQ: begin
                    if (redirect) pc_nxt = target;
                    if (imem_hs) begin
                        state_nxt = S_WAIT;
                        drop_nxt  = redirect;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        pc_nxt = target;
                        if (iIMEM_RVALID) begin
                            drop_nxt  = 1'b0;
                            state_nxt = S_REQ;
                        end else begin
                            drop_nxt  = 1'b1;
                        end
                    end else if (iIMEM_RVALID) begin
                        if (drop) begin
                            drop_nxt  = 1'b0;
                            state_nxt = S_REQ;
                        end else begin
                            ir_nxt    = iIMEM_RDATA;
                            ir_pc_nxt = pc;
                            pc_nxt    = pc + 32'(PC_STEP);
                            state_nxt = S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (redirect) begin
                        pc_nxt    = target;
                        state_nxt = S_REQ;
                    end else if (ir_hs) begin
                        state_nxt = S_REQ;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed bench for fetch_pc_sequencer: per-cycle vector table plus
// hand sequences for stalls, misaligned-target trap, PC wrap and mid-run reset.
module tb_fetch_pc_sequencer;

    logic        iCLK;
    logic        iRST;
    logic        oIMEM_VALID;
    logic [31:0] oIMEM_ADDR;
    logic        iIMEM_READY;
    logic        iIMEM_RVALID;
    logic [31:0] iIMEM_RDATA;
    logic        oIR_VALID;
    logic [31:0] oIR;
    logic [31:0] oIR_PC;
    logic        iIR_READY;
    logic        iBR_VALID;
    logic        iBR_TAKEN;
    logic [31:0] iBR_PC;
    logic [31:0] iBR_OFFSET;
    logic        oTRAP;

    int total = 0;
    int bad   = 0;

    fetch_pc_sequencer dut (
        .iCLK(iCLK), .iRST(iRST),
        .oIMEM_VALID(oIMEM_VALID), .oIMEM_ADDR(oIMEM_ADDR),
        .iIMEM_READY(iIMEM_READY), .iIMEM_RVALID(iIMEM_RVALID), .iIMEM_RDATA(iIMEM_RDATA),
        .oIR_VALID(oIR_VALID), .oIR(oIR), .oIR_PC(oIR_PC), .iIR_READY(iIR_READY),
        .iBR_VALID(iBR_VALID), .iBR_TAKEN(iBR_TAKEN), .iBR_PC(iBR_PC), .iBR_OFFSET(iBR_OFFSET),
        .oTRAP(oTRAP)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    typedef struct {
        logic        rst, rdy, rv;
        logic [31:0] rdata;
        logic        irr, bv, bt;
        logic [31:0] bpc, boff;
        logic        e_iv;
        logic [31:0] e_addr;
        logic        e_irv;
        logic [31:0] e_ir, e_irpc;
        logic        e_trap;
    } vec_t;

    function automatic vec_t mk(logic rst, logic rdy, logic rv, logic [31:0] rdata, logic irr,
                                logic bv, logic bt, logic [31:0] bpc, logic [31:0] boff,
                                logic e_iv, logic [31:0] e_addr, logic e_irv,
                                logic [31:0] e_ir, logic [31:0] e_irpc, logic e_trap);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.rv = rv; v.rdata = rdata; v.irr = irr;
        v.bv = bv; v.bt = bt; v.bpc = bpc; v.boff = boff;
        v.e_iv = e_iv; v.e_addr = e_addr; v.e_irv = e_irv;
        v.e_ir = e_ir; v.e_irpc = e_irpc; v.e_trap = e_trap;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic rdy, input logic rv, input logic [31:0] rdata,
                         input logic irr, input logic bv, input logic bt,
                         input logic [31:0] bpc, input logic [31:0] boff);
        iRST = rst; iIMEM_READY = rdy; iIMEM_RVALID = rv; iIMEM_RDATA = rdata;
        iIR_READY = irr; iBR_VALID = bv; iBR_TAKEN = bt; iBR_PC = bpc; iBR_OFFSET = boff;
        #1;
    endtask

    task automatic expect6(input string tag, input logic iv, input logic [31:0] addr, input logic irv,
                           input logic [31:0] ir, input logic [31:0] irpc, input logic trap);
        chk({tag, ".imem_valid"}, 32'(oIMEM_VALID), 32'(iv));
        chk({tag, ".imem_addr"},  oIMEM_ADDR, addr);
        chk({tag, ".ir_valid"},   32'(oIR_VALID), 32'(irv));
        chk({tag, ".ir"},         oIR, ir);
        chk({tag, ".ir_pc"},      oIR_PC, irpc);
        chk({tag, ".trap"},       32'(oTRAP), 32'(trap));
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    localparam logic [31:0] NEG8 = 32'hFFFF_FFF8;
    vec_t tbl[32];

    initial begin
        // rst rdy rv rdata irr bv bt bpc boff | iv addr irv ir irpc trap
        tbl[0]  = mk(1,0,0,0,0, 0,0,0,0,          0,32'h0,  0,32'h0,  32'h0,  0);
        tbl[1]  = mk(0,1,0,0,0, 0,0,0,0,          1,32'h0,  0,32'h0,  32'h0,  0);
        tbl[2]  = mk(0,0,1,32'hA0,0, 0,0,0,0,     0,32'h0,  0,32'h0,  32'h0,  0);
        tbl[3]  = mk(0,0,0,0,1, 0,0,0,0,          0,32'h4,  1,32'hA0, 32'h0,  0);
        tbl[4]  = mk(0,1,0,0,0, 0,0,0,0,          1,32'h4,  0,32'hA0, 32'h0,  0);
        tbl[5]  = mk(0,0,1,32'hA1,0, 0,0,0,0,     0,32'h4,  0,32'hA0, 32'h0,  0);
        tbl[6]  = mk(0,0,0,0,1, 0,0,0,0,          0,32'h8,  1,32'hA1, 32'h4,  0);
        tbl[7]  = mk(0,1,0,0,0, 0,0,0,0,          1,32'h8,  0,32'hA1, 32'h4,  0);
        tbl[8]  = mk(0,0,1,32'hA2,0, 0,0,0,0,     0,32'h8,  0,32'hA1, 32'h4,  0);
        tbl[9]  = mk(0,0,0,0,1, 0,0,0,0,          0,32'hC,  1,32'hA2, 32'h8,  0);
        tbl[10] = mk(0,1,0,0,0, 0,0,0,0,          1,32'hC,  0,32'hA2, 32'h8,  0);
        // taken branch 0x10-8 while waiting: returning data is dropped, refetch 0x08
        tbl[11] = mk(0,0,0,0,0, 1,1,32'h10,NEG8,  0,32'hC,  0,32'hA2, 32'h8,  0);
        tbl[12] = mk(0,0,1,32'hDEAD,0, 0,0,0,0,   0,32'h8,  0,32'hA2, 32'h8,  0);
        tbl[13] = mk(0,1,0,0,0, 0,0,0,0,          1,32'h8,  0,32'hA2, 32'h8,  0);
        tbl[14] = mk(0,0,1,32'hB8,0, 0,0,0,0,     0,32'h8,  0,32'hA2, 32'h8,  0);
        // taken branch together with decode handshake in S_OUT
        tbl[15] = mk(0,0,0,0,1, 1,1,32'h10,32'h20, 0,32'hC, 1,32'hB8, 32'h8,  0);
        // not-taken branches in every state leave the sequence alone
        tbl[16] = mk(0,0,0,0,0, 1,0,32'h500,0,    1,32'h30, 0,32'hB8, 32'h8,  0);
        tbl[17] = mk(0,1,0,0,0, 1,0,32'h500,0,    1,32'h30, 0,32'hB8, 32'h8,  0);
        tbl[18] = mk(0,0,0,0,0, 1,0,32'h500,0,    0,32'h30, 0,32'hB8, 32'h8,  0);
        tbl[19] = mk(0,0,1,32'hC0,0, 1,0,32'h500,0, 0,32'h30, 0,32'hB8, 32'h8, 0);
        tbl[20] = mk(0,0,0,0,0, 1,0,32'h500,0,    0,32'h34, 1,32'hC0, 32'h30, 0);
        tbl[21] = mk(0,0,0,0,1, 1,0,32'h500,0,    0,32'h34, 1,32'hC0, 32'h30, 0);
        // taken branch with request handshake: accepted fetch becomes wrong-path
        tbl[22] = mk(0,1,0,0,0, 1,1,32'h100,32'h40, 1,32'h34, 0,32'hC0, 32'h30, 0);
        tbl[23] = mk(0,0,1,32'hEE,0, 0,0,0,0,     0,32'h140,0,32'hC0, 32'h30, 0);
        tbl[24] = mk(0,0,0,0,0, 0,0,0,0,          1,32'h140,0,32'hC0, 32'h30, 0);
        // taken branch in S_REQ without handshake: address simply moves
        tbl[25] = mk(0,0,0,0,0, 1,1,32'h200,32'h10, 1,32'h140,0,32'hC0, 32'h30, 0);
        tbl[26] = mk(0,1,0,0,0, 0,0,0,0,          1,32'h210,0,32'hC0, 32'h30, 0);
        // taken branch on the same cycle as RVALID
        tbl[27] = mk(0,0,1,32'hBAD,0, 1,1,32'h300,0, 0,32'h210,0,32'hC0, 32'h30, 0);
        // RVALID while in S_REQ is ignored
        tbl[28] = mk(0,0,1,32'hFF,0, 0,0,0,0,     1,32'h300,0,32'hC0, 32'h30, 0);
        tbl[29] = mk(0,1,0,0,0, 0,0,0,0,          1,32'h300,0,32'hC0, 32'h30, 0);
        tbl[30] = mk(0,0,1,32'h11,0, 0,0,0,0,     0,32'h300,0,32'hC0, 32'h30, 0);
        tbl[31] = mk(0,0,0,0,1, 0,0,0,0,          0,32'h304,1,32'h11, 32'h300,0);

        drive(1,0,0,0,0,0,0,0,0);
        tick();
        tick();

        for (int i = 0; i < 32; i++) begin
            drive(tbl[i].rst, tbl[i].rdy, tbl[i].rv, tbl[i].rdata, tbl[i].irr,
                  tbl[i].bv, tbl[i].bt, tbl[i].bpc, tbl[i].boff);
            expect6($sformatf("vec%0d", i), tbl[i].e_iv, tbl[i].e_addr, tbl[i].e_irv,
                    tbl[i].e_ir, tbl[i].e_irpc, tbl[i].e_trap);
            tick();
        end

        // memory not ready for 5 cycles: request and address held
        for (int i = 0; i < 5; i++) begin
            drive(0,0,0,0,0,0,0,0,0);
            chk("stall.imem_valid", 32'(oIMEM_VALID), 32'd1);
            chk("stall.imem_addr", oIMEM_ADDR, 32'h304);
            tick();
        end
        drive(0,1,0,0,0,0,0,0,0);
        chk("stall.accept", 32'(oIMEM_VALID), 32'd1);
        tick();
        drive(0,0,1,32'h22,0,0,0,0,0);
        tick();
        // decode not ready for 4 cycles: instruction held
        for (int i = 0; i < 4; i++) begin
            drive(0,0,0,0,0,0,0,0,0);
            expect6("irhold", 0, 32'h308, 1, 32'h22, 32'h304, 0);
            tick();
        end
        drive(0,0,0,0,1,0,0,0,0);
        chk("irhold.release", 32'(oIR_VALID), 32'd1);
        tick();

        // misaligned target 0x100+2 traps and freezes
        drive(0,0,0,0,0,1,1,32'h100,32'h2);
        chk("trap.pre", 32'(oTRAP), 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0,1,1,32'h55,1,0,0,0,0);
            chk("halt.imem_valid", 32'(oIMEM_VALID), 32'd0);
            chk("halt.ir_valid", 32'(oIR_VALID), 32'd0);
            chk("halt.trap", 32'(oTRAP), 32'd1);
            tick();
        end
        drive(1,1,0,0,0,0,0,0,0);
        chk("rst.imem_valid_in_reset", 32'(oIMEM_VALID), 32'd0);
        tick();
        drive(0,0,0,0,0,0,0,0,0);
        expect6("after_rst", 1, 32'h0, 0, 32'h0, 32'h0, 0);

        // PC increment wraps past 0xFFFFFFFC
        drive(0,0,0,0,0,1,1,32'hFFFF_FFF0,32'hC);
        tick();
        drive(0,1,0,0,0,0,0,0,0);
        chk("wrap.addr", oIMEM_ADDR, 32'hFFFF_FFFC);
        tick();
        drive(0,0,1,32'h33,0,0,0,0,0);
        tick();
        drive(0,0,0,0,1,0,0,0,0);
        expect6("wrap.out", 0, 32'h0, 1, 32'h33, 32'hFFFF_FFFC, 0);
        tick();

        // reset while a read is outstanding; the late RVALID is ignored
        drive(0,1,0,0,0,0,0,0,0);
        tick();
        drive(1,0,0,0,0,0,0,0,0);
        tick();
        drive(0,0,1,32'h44,0,0,0,0,0);
        expect6("midrst", 1, 32'h0, 0, 32'h0, 32'h0, 0);
        tick();
        drive(0,0,0,0,0,0,0,0,0);
        expect6("midrst.late_rvalid", 1, 32'h0, 0, 32'h0, 32'h0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, total=%0d", total);
        $fatal(1, "timeout");
    end

endmodule
